sdram_req_bridge: RTL and testbench
===================================

Name: sdram_req_bridge

Overview:
- Sits directly upstream of the mmu SDRAM controller.
- Converts CPU-side 32-bit word read/write requests into one or two 16-bit halfword accesses on the mmu request port.
- For reads, reassembles the two returned halfwords into a single 32-bit response.
- One transaction in flight at a time; backpressure is applied to the CPU through req_ready.

Parameters:
- WADDR_W, 21, CPU word-address width (SDRAM halfword address is WADDR_W+1 = 22 bits: 2 bank + 12 row + 8 col).
- RD_TIMEOUT, 255, max cycles to wait for mmu_rvalid per halfword before flagging an error.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous reset, active-high
- req_valid  in  1  CPU request present
- req_ready  out  1  bridge accepts request this cycle
- req_we  in  1  1 = write, 0 = read
- req_addr  in  WADDR_W  word address
- req_wdata  in  32  write data, little-endian
- req_be  in  4  byte enables (writes only)
- resp_valid  out  1  one-cycle pulse: read data valid / write done
- resp_rdata  out  32  read data
- resp_err  out  1  valid with resp_valid; read timeout occurred
- mmu_valid  out  1  halfword command to mmu
- mmu_ready  in  1  mmu accepts command
- mmu_we  out  1  halfword write
- mmu_addr  out  WADDR_W+1  halfword address
- mmu_wdata  out  16  halfword write data
- mmu_dqm  out  2  active-high byte masks (S_DQM polarity)
- mmu_rvalid  in  1  read halfword returned
- mmu_rdata  in  16  returned halfword

Behaviour:
- Reset values: req_ready=0, resp_valid=0, resp_rdata=0, resp_err=0, mmu_valid=0, mmu_we=0, mmu_addr=0, mmu_wdata=0, mmu_dqm=2'b11; state=IDLE.
- Reset mid-transaction aborts immediately. A halfword already accepted by the mmu is not re-issued. No resp is produced.
- States: IDLE, CMD_LO, WAIT_LO, CMD_HI, WAIT_HI, RESP.
- IDLE:
  - req_ready=1.
  - On req_valid: latch we/addr/wdata/be, deassert req_ready next cycle, go to CMD_LO.
  - Exception: for a write with be[1:0]==0, skip to CMD_HI.
  - For a write with be==0: go straight to RESP (no mmu traffic).
- CMD_LO:
  - mmu_valid=1, mmu_addr={addr,1'b0}, mmu_wdata=wdata[15:0], mmu_dqm=~be[1:0] for writes, 2'b00 for reads.
  - Hold all mmu outputs stable until mmu_ready.
  - On accept, the next state depends on the operation:
    - read -> WAIT_LO
    - write with be[3:2]!=0 -> CMD_HI
    - otherwise -> RESP
- WAIT_LO:
  - On mmu_rvalid, capture rdata into resp_rdata[15:0] and go to CMD_HI.
  - If the wait counter reaches RD_TIMEOUT: set the err flag, fill the half with 16'h0000, go to CMD_HI.
- CMD_HI: as CMD_LO with mmu_addr={addr,1'b1}, wdata[31:16], dqm=~be[3:2]. Read -> WAIT_HI, write -> RESP.
- WAIT_HI: as WAIT_LO into resp_rdata[31:16], then RESP.
- RESP:
  - resp_valid=1 for exactly one cycle with resp_err, then IDLE.
  - req_ready returns to 1 in the cycle after RESP.
  - Minimum turnaround is one idle cycle between transactions.
- mmu_valid deasserts the cycle after handshake. No back-to-back halfword issue in the same cycle as acceptance.
- Latency (mmu_ready tied 1, read data returned N cycles after accept), measured from request accept to resp_valid: read = 2N+4 cycles, full write = 4 cycles.
- mmu_rvalid outside WAIT_LO/WAIT_HI is ignored.
- The timeout counter clears on entry to each WAIT state.
- resp_rdata is held until the next read response. Writes leave it unchanged.

Test Plan:
- Reset: hold rst=1 for 3 cycles with req_valid=1 -> req_ready=0, mmu_valid=0, mmu_dqm=2'b11. After release, req_ready=1.
- Full write: addr=21'h00010, wdata=32'hDEADBEEF, be=4'hF. Expect two mmu commands: (22'h000020, 16'hBEEF, dqm 00) then (22'h000021, 16'hDEAD, dqm 00). resp_valid pulses once with err=0.
- Partial writes:
  - be=4'b0010 -> a single command at the low halfword with wdata 16'hBEEF, dqm=2'b01; no high command.
  - be=4'b1100 -> only the high command is issued.
  - be=0 -> no mmu traffic; resp_valid follows.
- Read: addr=21'h1FFFFF; the mmu model returns 16'h1234 then 16'h5678, each 3 cycles after accept, with mmu_ready stalled 2 cycles on the first command. Expect mmu_addr 22'h3FFFFE then 22'h3FFFFF, resp_rdata=32'h56781234, err=0.
- Timeout: read with no mmu_rvalid for the low half. Expect resp_valid after RD_TIMEOUT+ cycles, resp_err=1, resp_rdata[15:0]=0.
- Reset mid-read: assert rst in WAIT_LO. Expect no resp_valid, state returns to IDLE, a subsequent read completes correctly.

Source files
------------

// File: rtl/sdram_req_bridge.sv
// sdram_req_bridge: splits 32-bit CPU word requests into 16-bit halfword
// commands for the mmu SDRAM controller and reassembles read halves into
// one 32-bit response. One transaction in flight at a time.
module sdram_req_bridge #(
    parameter int WADDR_W    = 21,
    parameter int RD_TIMEOUT = 255
) (
    input  logic               i_clk,
    input  logic               i_rst,
    input  logic               i_req_valid,
    output logic               o_req_ready,
    input  logic               i_req_we,
    input  logic [WADDR_W-1:0] i_req_addr,
    input  logic [31:0]        i_req_wdata,
    input  logic [3:0]         i_req_be,
    output logic               o_resp_valid,
    output logic [31:0]        o_resp_rdata,
    output logic               o_resp_err,
    output logic               o_mmu_valid,
    input  logic               i_mmu_ready,
    output logic               o_mmu_we,
    output logic [WADDR_W:0]   o_mmu_addr,
    output logic [15:0]        o_mmu_wdata,
    output logic [1:0]         o_mmu_dqm,
    input  logic               i_mmu_rvalid,
    input  logic [15:0]        i_mmu_rdata
);
    localparam int CNT_W = $clog2(RD_TIMEOUT + 1);

    typedef enum logic [2:0] {
        IDLE, CMD_LO, WAIT_LO, CMD_HI, WAIT_HI, RESP
    } state_t;

    state_t               r_state;
    logic                 r_we;
    logic [WADDR_W-1:0]   r_addr;
    logic [31:0]          r_wdata;
    logic [3:0]           r_be;
    logic [15:0]          r_rd_lo;
    logic                 r_err;
    logic [CNT_W-1:0]     r_cnt;
    logic                 r_req_ready;
    logic                 r_resp_valid;
    logic [31:0]          r_resp_rdata;
    logic                 r_resp_err;
    logic                 r_mmu_valid;
    logic                 r_mmu_we;
    logic [WADDR_W:0]     r_mmu_addr;
    logic [15:0]          r_mmu_wdata;
    logic [1:0]           r_mmu_dqm;

    wire w_timeout = (r_cnt == CNT_W'(RD_TIMEOUT));

    assign o_req_ready  = r_req_ready;
    assign o_resp_valid = r_resp_valid;
    assign o_resp_rdata = r_resp_rdata;
    assign o_resp_err   = r_resp_err;
    assign o_mmu_valid  = r_mmu_valid;
    assign o_mmu_we     = r_mmu_we;
    assign o_mmu_addr   = r_mmu_addr;
    assign o_mmu_wdata  = r_mmu_wdata;
    assign o_mmu_dqm    = r_mmu_dqm;

    // Transaction FSM. Each CMD state spends its first cycle raising the
    // command, then holds it until the mmu accepts; responses are raised on
    // entry to RESP so resp_valid coincides with the RESP state.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state      <= IDLE;
            r_we         <= 1'b0;
            r_addr       <= '0;
            r_wdata      <= '0;
            r_be         <= '0;
            r_rd_lo      <= '0;
            r_err        <= 1'b0;
            r_cnt        <= '0;
            r_req_ready  <= 1'b0;
            r_resp_valid <= 1'b0;
            r_resp_rdata <= '0;
            r_resp_err   <= 1'b0;
            r_mmu_valid  <= 1'b0;
            r_mmu_we     <= 1'b0;
            r_mmu_addr   <= '0;
            r_mmu_wdata  <= '0;
            r_mmu_dqm    <= 2'b11;
        end else begin
            r_resp_valid <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (!r_req_ready) begin
                        r_req_ready <= 1'b1;
                    end else if (i_req_valid) begin
                        r_req_ready <= 1'b0;
                        r_we        <= i_req_we;
                        r_addr      <= i_req_addr;
                        r_wdata     <= i_req_wdata;
                        r_be        <= i_req_be;
                        r_err       <= 1'b0;
                        if (i_req_we && i_req_be == 4'b0000) begin
                            r_state      <= RESP;
                            r_resp_valid <= 1'b1;
                            r_resp_err   <= 1'b0;
                        end else if (i_req_we && i_req_be[1:0] == 2'b00) begin
                            r_state <= CMD_HI;
                        end else begin
                            r_state <= CMD_LO;
                        end
                    end
                end
                CMD_LO: begin
                    if (!r_mmu_valid) begin
                        r_mmu_valid <= 1'b1;
                        r_mmu_we    <= r_we;
                        r_mmu_addr  <= {r_addr, 1'b0};
                        r_mmu_wdata <= r_wdata[15:0];
                        r_mmu_dqm   <= r_we ? ~r_be[1:0] : 2'b00;
                    end else if (i_mmu_ready) begin
                        r_mmu_valid <= 1'b0;
                        if (!r_we) begin
                            r_state <= WAIT_LO;
                            r_cnt   <= '0;
                        end else if (r_be[3:2] != 2'b00) begin
                            r_state <= CMD_HI;
                        end else begin
                            r_state      <= RESP;
                            r_resp_valid <= 1'b1;
                            r_resp_err   <= 1'b0;
                        end
                    end
                end
                WAIT_LO: begin
                    if (i_mmu_rvalid) begin
                        r_rd_lo <= i_mmu_rdata;
                        r_state <= CMD_HI;
                    end else if (w_timeout) begin
                        r_rd_lo <= 16'h0000;
                        r_err   <= 1'b1;
                        r_state <= CMD_HI;
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end
                CMD_HI: begin
                    if (!r_mmu_valid) begin
                        r_mmu_valid <= 1'b1;
                        r_mmu_we    <= r_we;
                        r_mmu_addr  <= {r_addr, 1'b1};
                        r_mmu_wdata <= r_wdata[31:16];
                        r_mmu_dqm   <= r_we ? ~r_be[3:2] : 2'b00;
                    end else if (i_mmu_ready) begin
                        r_mmu_valid <= 1'b0;
                        if (!r_we) begin
                            r_state <= WAIT_HI;
                            r_cnt   <= '0;
                        end else begin
                            r_state      <= RESP;
                            r_resp_valid <= 1'b1;
                            r_resp_err   <= 1'b0;
                        end
                    end
                end
                WAIT_HI: begin
                    if (i_mmu_rvalid) begin
                        r_resp_rdata <= {i_mmu_rdata, r_rd_lo};
                        r_resp_err   <= r_err;
                        r_resp_valid <= 1'b1;
                        r_state      <= RESP;
                    end else if (w_timeout) begin
                        r_resp_rdata <= {16'h0000, r_rd_lo};
                        r_resp_err   <= 1'b1;
                        r_resp_valid <= 1'b1;
                        r_state      <= RESP;
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end
                RESP: begin
                    r_state     <= IDLE;
                    r_req_ready <= 1'b1;
                end
                default: r_state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_sdram_req_bridge.sv
// Self-checking bench for sdram_req_bridge: an mmu responder model with
// configurable stall / read latency / dropped halves, and a word-level
// reference of which halfword commands and responses each request produces.
module tb_sdram_req_bridge;
    localparam int WADDR_W    = 21;
    localparam int RD_TIMEOUT = 255;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic req_valid, req_ready, req_we;
    logic [WADDR_W-1:0] req_addr;
    logic [31:0] req_wdata;
    logic [3:0]  req_be;
    logic resp_valid, resp_err;
    logic [31:0] resp_rdata;
    logic mmu_valid, mmu_ready, mmu_we, mmu_rvalid;
    logic [WADDR_W:0] mmu_addr;
    logic [15:0] mmu_wdata, mmu_rdata;
    logic [1:0]  mmu_dqm;

    sdram_req_bridge #(.WADDR_W(WADDR_W), .RD_TIMEOUT(RD_TIMEOUT)) dut (
        .i_clk(clk), .i_rst(rst),
        .i_req_valid(req_valid), .o_req_ready(req_ready), .i_req_we(req_we),
        .i_req_addr(req_addr), .i_req_wdata(req_wdata), .i_req_be(req_be),
        .o_resp_valid(resp_valid), .o_resp_rdata(resp_rdata), .o_resp_err(resp_err),
        .o_mmu_valid(mmu_valid), .i_mmu_ready(mmu_ready), .o_mmu_we(mmu_we),
        .o_mmu_addr(mmu_addr), .o_mmu_wdata(mmu_wdata), .o_mmu_dqm(mmu_dqm),
        .i_mmu_rvalid(mmu_rvalid), .i_mmu_rdata(mmu_rdata)
    );

    always #5 clk = ~clk;

    int unsigned cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;

    typedef struct packed {
        logic        we;
        logic [21:0] addr;
        logic [15:0] wdata;
        logic [1:0]  dqm;
    } cmd_t;

    // mmu model state and knobs
    cmd_t        log_q[$];
    int unsigned pend_edge[$];
    logic [15:0] pend_data[$];
    int unsigned rd_lat = 3;
    int          stall_next = 0;
    bit          rand_stall = 0;
    bit          use_fixed = 0;
    bit          drop_lo = 0, drop_hi = 0;
    bit          noise = 0;
    logic [15:0] fix_lo = 0, fix_hi = 0;
    logic [15:0] ret_lo = 0, ret_hi = 0;
    logic [31:0] model_rdata = 0;

    // mmu responder: decides ready each cycle, logs accepted commands and
    // returns read data rd_lat edges after acceptance
    initial begin
        bit          in_cmd;
        int          stall_left;
        cmd_t        first_seen, cur;
        logic [15:0] d;
        in_cmd = 0;
        stall_left = 0;
        mmu_ready = 0; mmu_rvalid = 0; mmu_rdata = 0;
        forever begin
            @(negedge clk);
            mmu_rvalid = 0;
            mmu_ready  = 0;
            if (rst) begin
                pend_edge.delete();
                pend_data.delete();
                in_cmd = 0;
            end else begin
                if (pend_edge.size() > 0 && pend_edge[0] == cyc + 1) begin
                    mmu_rvalid = 1;
                    mmu_rdata  = pend_data[0];
                    void'(pend_edge.pop_front());
                    void'(pend_data.pop_front());
                end else if (noise && ($urandom_range(0, 2) == 0)) begin
                    mmu_rvalid = 1;
                    mmu_rdata  = 16'($urandom);
                end
                if (mmu_valid) begin
                    cur = '{mmu_we, mmu_addr, mmu_wdata, mmu_dqm};
                    if (!in_cmd) begin
                        in_cmd     = 1;
                        first_seen = cur;
                        stall_left = rand_stall ? int'($urandom_range(0, 2)) : stall_next;
                        stall_next = 0;
                    end
                    if (stall_left > 0) begin
                        stall_left--;
                    end else begin
                        mmu_ready = 1;
                        in_cmd    = 0;
                        checks++;
                        if (cur !== first_seen) begin
                            errors++;
                            $display("FAIL mmu_hold got %h expected %h", cur, first_seen);
                        end
                        log_q.push_back(cur);
                        if (!mmu_we) begin
                            d = use_fixed ? (mmu_addr[0] ? fix_hi : fix_lo) : 16'($urandom);
                            if (mmu_addr[0]) ret_hi = d; else ret_lo = d;
                            if (!(mmu_addr[0] ? drop_hi : drop_lo)) begin
                                pend_edge.push_back(cyc + 1 + rd_lat);
                                pend_data.push_back(d);
                            end
                        end
                    end
                end
            end
        end
    end

    // Issue one request, wait for its response, compare commands and result
    // against the word-level reference. lat = edges from accept to resp_valid.
    task automatic run_txn(input string name, input logic we, input logic [20:0] addr,
                           input logic [31:0] wdata, input logic [3:0] be, output int lat);
        cmd_t        exp_q[$];
        logic [31:0] exp_rdata;
        logic        exp_err;
        int          acc_edge;
        bit          got;
        lat = -1;
        if (we) begin
            if (be[1:0] != 2'b00) exp_q.push_back('{1'b1, {addr, 1'b0}, wdata[15:0], ~be[1:0]});
            if (be[3:2] != 2'b00) exp_q.push_back('{1'b1, {addr, 1'b1}, wdata[31:16], ~be[3:2]});
        end else begin
            exp_q.push_back('{1'b0, {addr, 1'b0}, 16'h0, 2'b00});
            exp_q.push_back('{1'b0, {addr, 1'b1}, 16'h0, 2'b00});
        end
        log_q.delete();
        @(negedge clk);
        req_valid = 1; req_we = we; req_addr = addr; req_wdata = wdata; req_be = be;
        got = 0;
        for (int i = 0; i < 50 && !got; i++) begin
            if (req_ready) got = 1; else @(negedge clk);
        end
        checks++;
        if (!got) begin
            errors++;
            $display("FAIL %s accept got no req_ready expected ready within 50 cycles", name);
            req_valid = 0;
            return;
        end
        acc_edge = cyc + 1;
        @(negedge clk);
        req_valid = 0;
        req_we = 1'($urandom); req_addr = 21'($urandom); req_wdata = $urandom; req_be = 4'($urandom);
        checks++;
        if (req_ready !== 1'b0) begin
            errors++;
            $display("FAIL %s ready_drop got %b expected 0", name, req_ready);
        end
        got = 0;
        for (int i = 0; i < 3000 && !got; i++) begin
            if (resp_valid) got = 1; else @(negedge clk);
        end
        checks++;
        if (!got) begin
            errors++;
            $display("FAIL %s resp got none expected resp_valid within 3000 cycles", name);
            return;
        end
        lat = cyc - acc_edge;
        if (we) begin
            exp_rdata = model_rdata;
            exp_err   = 0;
        end else begin
            exp_rdata = {drop_hi ? 16'h0 : ret_hi, drop_lo ? 16'h0 : ret_lo};
            exp_err   = drop_lo | drop_hi;
            model_rdata = exp_rdata;
        end
        checks++;
        if (resp_rdata !== exp_rdata || resp_err !== exp_err) begin
            errors++;
            $display("FAIL %s resp got rdata=%h err=%b expected rdata=%h err=%b",
                     name, resp_rdata, resp_err, exp_rdata, exp_err);
        end
        @(negedge clk);
        checks++;
        if (resp_valid !== 1'b0 || req_ready !== 1'b1) begin
            errors++;
            $display("FAIL %s after_resp got valid=%b ready=%b expected valid=0 ready=1",
                     name, resp_valid, req_ready);
        end
        checks++;
        if (log_q.size() != exp_q.size()) begin
            errors++;
            $display("FAIL %s cmd_count got %0d expected %0d", name, log_q.size(), exp_q.size());
        end else begin
            foreach (exp_q[k]) begin
                checks++;
                if (log_q[k].we !== exp_q[k].we || log_q[k].addr !== exp_q[k].addr ||
                    log_q[k].dqm !== exp_q[k].dqm ||
                    (exp_q[k].we && log_q[k].wdata !== exp_q[k].wdata)) begin
                    errors++;
                    $display("FAIL %s cmd%0d got %h expected %h", name, k, log_q[k], exp_q[k]);
                end
            end
        end
    endtask

    task automatic test_reset();
        rst = 1; req_valid = 1; req_we = 0; req_addr = 0; req_wdata = 0; req_be = 0;
        repeat (3) @(negedge clk);
        checks++;
        if (req_ready !== 0 || mmu_valid !== 0 || mmu_dqm !== 2'b11 || resp_valid !== 0 ||
            resp_rdata !== 0 || resp_err !== 0 || mmu_we !== 0 || mmu_addr !== 0 || mmu_wdata !== 0) begin
            errors++;
            $display("FAIL reset_vals got ready=%b mv=%b dqm=%b rv=%b rd=%h err=%b we=%b a=%h wd=%h expected 0,0,11,0,0,0,0,0,0",
                     req_ready, mmu_valid, mmu_dqm, resp_valid, resp_rdata, resp_err, mmu_we, mmu_addr, mmu_wdata);
        end
        req_valid = 0;
        rst = 0;
        model_rdata = 0;
        repeat (2) @(negedge clk);
        checks++;
        if (req_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_release got ready=%b expected 1", req_ready);
        end
    endtask

    task automatic test_full_write();
        int lat;
        run_txn("full_write", 1, 21'h00010, 32'hDEADBEEF, 4'hF, lat);
        checks++;
        if (lat != 4) begin
            errors++;
            $display("FAIL write_latency got %0d expected 4", lat);
        end
    endtask

    task automatic test_partial_writes();
        int lat;
        noise = 1;
        run_txn("wr_be0010", 1, 21'h00010, 32'hDEADBEEF, 4'b0010, lat);
        run_txn("wr_be1100", 1, 21'h0ABCD, 32'hDEADBEEF, 4'b1100, lat);
        run_txn("wr_be0000", 1, 21'h00777, 32'h12345678, 4'b0000, lat);
        noise = 0;
    endtask

    task automatic test_read();
        int lat;
        use_fixed = 1; fix_lo = 16'h1234; fix_hi = 16'h5678; rd_lat = 3; stall_next = 2;
        run_txn("read_top", 0, 21'h1FFFFF, 32'h0, 4'h0, lat);
        fix_lo = 16'hA5A5; fix_hi = 16'h0F0F; stall_next = 0;
        run_txn("read_lat", 0, 21'h00123, 32'h0, 4'h0, lat);
        checks++;
        if (lat != 2 * 3 + 4) begin
            errors++;
            $display("FAIL read_latency got %0d expected %0d", lat, 2 * 3 + 4);
        end
        use_fixed = 0;
    endtask

    task automatic test_timeout();
        int lat;
        drop_lo = 1; rd_lat = 3;
        run_txn("timeout_lo", 0, 21'h05555, 32'h0, 4'h0, lat);
        checks++;
        if (lat < RD_TIMEOUT || lat > RD_TIMEOUT + 2 * 3 + 10) begin
            errors++;
            $display("FAIL timeout_latency got %0d expected %0d..%0d", lat, RD_TIMEOUT, RD_TIMEOUT + 16);
        end
        drop_lo = 0;
        run_txn("write_keeps_rdata", 1, 21'h00001, 32'hCAFEF00D, 4'hF, lat);
    endtask

    task automatic test_reset_mid_read();
        bit got;
        bit saw;
        int lat;
        drop_lo = 1;
        log_q.delete();
        @(negedge clk);
        req_valid = 1; req_we = 0; req_addr = 21'h0F0F0; req_be = 0;
        got = 0;
        for (int i = 0; i < 50 && !got; i++) begin
            if (req_ready) got = 1; else @(negedge clk);
        end
        @(negedge clk);
        req_valid = 0;
        got = 0;
        for (int i = 0; i < 50 && !got; i++) begin
            if (log_q.size() > 0) got = 1; else @(negedge clk);
        end
        checks++;
        if (!got) begin
            errors++;
            $display("FAIL midrd_lo_cmd got none expected low command within 50 cycles");
        end
        repeat (5) @(negedge clk);
        saw = 0;
        rst = 1;
        repeat (3) begin
            @(negedge clk);
            if (resp_valid) saw = 1;
        end
        checks++;
        if (req_ready !== 0 || mmu_valid !== 0) begin
            errors++;
            $display("FAIL midrd_in_reset got ready=%b mv=%b expected 0 0", req_ready, mmu_valid);
        end
        rst = 0; drop_lo = 0; model_rdata = 0;
        repeat (20) begin
            @(negedge clk);
            if (resp_valid || mmu_valid) saw = 1;
        end
        checks++;
        if (saw || req_ready !== 1'b1) begin
            errors++;
            $display("FAIL midrd_abort got stray=%b ready=%b expected stray=0 ready=1", saw, req_ready);
        end
        rd_lat = 2;
        run_txn("read_after_reset", 0, 21'h0F0F1, 32'h0, 4'h0, lat);
    endtask

    task automatic test_random();
        int   lat;
        logic we;
        rand_stall = 1;
        for (int n = 0; n < 40; n++) begin
            we      = 1'($urandom);
            rd_lat  = $urandom_range(1, 4);
            drop_lo = !we && ($urandom_range(0, 9) == 0);
            drop_hi = !we && ($urandom_range(0, 9) == 0);
            noise   = we;
            run_txn("random", we, 21'($urandom), $urandom, 4'($urandom), lat);
            noise = 0; drop_lo = 0; drop_hi = 0;
        end
        rand_stall = 0;
    endtask

    initial begin
        test_reset();
        test_full_write();
        test_partial_writes();
        test_read();
        test_timeout();
        test_reset_mid_read();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
